// File: rtl/sonar_emu_pkg.sv
// HC-SR04 responder emulator: shared types and constants.
// Register map, FSM state encoding and the sonar timeout length.
package sonar_emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_DELAY,
    ST_ECHO
  } state_e;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_ECHO   = 5'd1;
  localparam logic [4:0] ADDR_DELAY  = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;

  localparam logic [15:0] DELAY_RST  = 16'd200;
  localparam int          TIMEOUT_US = 38000;

endpackage

// File: rtl/hc_sr04_emu_core_if.sv
// FPro MMIO slot bus between the slot decoder and the emulator.
// The decoder is the master, the emulator core is the slave.
interface hc_sr04_emu_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer for an asynchronous level plus a registered
// history stage that yields single-cycle rise/fall pulses.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/hc_sr04_emu_core.sv
// HC-SR04 sonar responder: trigger qualify, delay, echo pulse.
// SONAR_EMU_TIMEOUT_EN: zero echo width emits the 38 ms timeout pulse.
module hc_sr04_emu_core
  import sonar_emu_pkg::*;
#(
  parameter int CLK_PER_US  = 100,
  parameter int TRIG_MIN_US = 10
) (
  input  logic               clk,
  input  logic               reset,
  hc_sr04_emu_core_if.slave  bus,
  input  logic               trig_in,
  output logic               echo_out
);

  localparam int CW  = $clog2(65535*CLK_PER_US+1);
  localparam int THR = TRIG_MIN_US*CLK_PER_US;
  localparam int HW  = $clog2(THR+1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hc_q, hc_d, hc_inc;
  logic [7:0]  rej_q, rej_d;
  logic [15:0] acc_q, acc_d;
  logic        echo_q, echo_d;
  logic        en_q, en_nx;
  logic [15:0] echo_us_q, delay_us_q;
  logic [15:0] sh_echo_q, sh_dly_q;
  logic        rise, fall;
  logic        rej_inc, acc_inc, sh_load;
  logic        wr_en, wr_ctrl, wr_echo;
  logic        wr_dly, cnt_clr, busy;
  logic [CW-1:0] dly_cyc, echo_cyc_sh;
  logic [CW-1:0] echo_cyc_live;
  logic        unused_ok;

  function automatic logic [CW-1:0] echo_cyc(
    input logic [15:0] w
  );
`ifdef SONAR_EMU_TIMEOUT_EN
    if (w == 16'd0)
      return CW'(TIMEOUT_US*CLK_PER_US);
`endif
    return CW'(32'(w)*CLK_PER_US);
  endfunction

  sync_edge_det u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (trig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign wr_en   = bus.cs & bus.write;
  assign wr_ctrl = wr_en & (bus.addr == ADDR_CTRL);
  assign wr_echo = wr_en & (bus.addr == ADDR_ECHO);
  assign wr_dly  = wr_en & (bus.addr == ADDR_DELAY);
  assign cnt_clr = wr_en & (bus.addr == ADDR_STATUS);
  // A CTRL write takes effect on the same edge it lands
  assign en_nx   = wr_ctrl ? bus.wr_data[0] : en_q;

  assign dly_cyc       = CW'(32'(sh_dly_q)*CLK_PER_US);
  assign echo_cyc_sh   = echo_cyc(sh_echo_q);
  assign echo_cyc_live = echo_cyc(echo_us_q);
  assign unused_ok     = ^{bus.read, bus.wr_data[31:16]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hc_q    <= '0;
      echo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      echo_q  <= echo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    hc_d    = hc_q;
    rej_inc = 1'b0;
    acc_inc = 1'b0;
    sh_load = 1'b0;
    hc_inc  = (hc_q == HW'(THR)) ? hc_q : hc_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_TRIG_HI;
          hc_d    = '0;
        end
      end
      ST_TRIG_HI: begin
        hc_d  = hc_inc;
        cnt_d = '0;
        if (fall) begin
          if (hc_inc >= HW'(THR)) begin
            acc_inc = 1'b1;
            sh_load = 1'b1;
            if (delay_us_q != 16'd0)
              state_d = ST_DELAY;
            else if (echo_cyc_live != '0)
              state_d = ST_ECHO;
            else
              state_d = ST_IDLE;
          end else begin
            rej_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DELAY: begin
        rej_inc = rise;
        if (cnt_q == dly_cyc - 1'b1) begin
          cnt_d   = '0;
          state_d = (echo_cyc_sh != '0) ?
                    ST_ECHO : ST_IDLE;
        end
      end
      ST_ECHO: begin
        rej_inc = rise;
        if (cnt_q == echo_cyc_sh - 1'b1)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en_nx) begin
      state_d = ST_IDLE;
      rej_inc = 1'b0;
      acc_inc = 1'b0;
      sh_load = 1'b0;
    end
  end

  always_comb begin
    echo_d = (state_d == ST_ECHO);
    busy   = (state_q != ST_IDLE);
  end

  assign echo_out = echo_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q       <= 1'b0;
      echo_us_q  <= 16'd0;
      delay_us_q <= DELAY_RST;
      sh_echo_q  <= 16'd0;
      sh_dly_q   <= 16'd0;
    end else begin
      if (wr_ctrl) en_q       <= bus.wr_data[0];
      if (wr_echo) echo_us_q  <= bus.wr_data[15:0];
      if (wr_dly)  delay_us_q <= bus.wr_data[15:0];
      if (sh_load) begin
        sh_echo_q <= echo_us_q;
        sh_dly_q  <= delay_us_q;
      end
    end
  end

  always_comb begin
    rej_d = rej_q;
    acc_d = acc_q;
    if (rej_inc && rej_q != 8'hFF)
      rej_d = rej_q + 1'b1;
    if (acc_inc)
      acc_d = acc_q + 1'b1;
    if (cnt_clr) begin
      rej_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rej_q <= '0;
      acc_q <= '0;
    end else begin
      rej_q <= rej_d;
      acc_q <= acc_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    unique case (1'b1)
      (bus.addr == ADDR_CTRL):
        bus.rd_data = {31'b0, en_q};
      (bus.addr == ADDR_ECHO):
        bus.rd_data = {16'b0, echo_us_q};
      (bus.addr == ADDR_DELAY):
        bus.rd_data = {16'b0, delay_us_q};
      (bus.addr == ADDR_STATUS):
        bus.rd_data = {acc_q, rej_q, 7'b0, busy};
      default: ;
    endcase
  end

endmodule
